// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock supervisor with staged reset release
//
// Purpose: drives the PLL reset, filters the synchronized PLL lock indication,
// releases staged accelerator resets in order once lock is stable, detects
// lock loss, retries on lock timeout and flags a sticky error when retries run out.
//
// Ports:
//   refclk      in   free-running reference clock (also feeds the PLL)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock output, asynchronous to refclk
//   pll_rst     out  reset to the PLL, active high
//   stage_rst   out  staged active-high resets, bit 0 released first
//   ready       out  all stages released and lock held
//   lock_lost   out  one-cycle pulse on lock loss during RELEASE or RUN
//   retry_count out  lock timeouts since the last RUN entry
//   error       out  sticky, retries exhausted
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int MAX_RETRIES        = 3,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP          = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [7:0]            retry_count,
  output logic                  error
);

  // The shared counter must reach the last release offset as well as the
  // three count parameters, so the release span takes part in the sizing.
  localparam int REL_LAST = (NUM_STAGES - 1) * STAGE_GAP;
  localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B    = (TIMEOUT_CYCLES > REL_LAST + 1) ? TIMEOUT_CYCLES : REL_LAST + 1;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] C_PLL_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_LS_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_REL_LAST = CW'(REL_LAST);
  localparam logic [7:0]    C_MAX_RETR = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_sync;
  logic                  r_pll_rst;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_ready;
  logic                  r_lock_lost;
  logic [7:0]            r_retry;
  logic                  r_error;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_cnt_inc;
  logic [7:0]            w_retry_nxt;
  logic                  w_lost_nxt;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic                  w_locked_s;

  assign w_locked_s = r_sync[1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_sync      <= 2'b00;
      r_pll_rst   <= 1'b1;
      r_stage_rst <= '1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= 8'd0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync      <= {r_sync[0], pll_locked};
      r_pll_rst   <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_ERROR);
      r_stage_rst <= w_stage_nxt;
      r_ready     <= (w_state_nxt == S_RUN);
      r_lock_lost <= w_lost_nxt;
      r_retry     <= w_retry_nxt;
      r_error     <= (w_state_nxt == S_ERROR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_retry_nxt = r_retry;
    w_lost_nxt  = 1'b0;
    w_stage_nxt = '1;

    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_PLL_LAST) w_state_nxt = S_WAIT_LOCK;
        else                     w_cnt_inc   = 1'b1;
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins over the retry.
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == C_TO_LAST) begin
          if (r_retry == C_MAX_RETR) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_retry_nxt = r_retry + 8'd1;
            w_state_nxt = S_PLL_RST;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout here is treated as a glitch: back to waiting, no PLL reset.
        if (!w_locked_s)              w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == C_LS_LAST)  w_state_nxt = S_RELEASE;
        else                          w_cnt_inc   = 1'b1;
      end
      S_RELEASE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_PLL_RST;
          w_lost_nxt  = 1'b1;
        end else if (r_cnt == C_REL_LAST) begin
          w_state_nxt = S_RUN;
          w_retry_nxt = 8'd0;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_PLL_RST;
          w_lost_nxt  = 1'b1;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt = S_PLL_RST;
      end
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    else if (w_cnt_inc)         w_cnt_nxt = r_cnt + CW'(1);
    else                        w_cnt_nxt = r_cnt;

    // Outputs are registered from the next state so stage 0 is already low
    // on the first RELEASE cycle.
    if (w_state_nxt == S_RUN) begin
      w_stage_nxt = '0;
    end else if (w_state_nxt == S_RELEASE) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        w_stage_nxt[k] = (w_cnt_nxt < CW'(k * STAGE_GAP));
      end
    end
  end

  assign pll_rst     = r_pll_rst;
  assign stage_rst   = r_stage_rst;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;
  assign error       = r_error;

endmodule
